tx_frame_arbiter: RTL and testbench

Shares the single 64-bit RS-232 frame transmitter (8 bytes, LSB-first byte order) between two requesters: the AES result path (req0) and the plaintext/diagnostic echo path (req1). Each request carries a 64-bit block over a valid/ready handshake. The arbiter grants round-robin, hands the block to the transmitter with a one-cycle start pulse and waits for frame completion. It then enforces an idle gap before the next grant and flags transmitters that never start.

---
 rtl/rs232_pkg.sv | 16 +
 rtl/tx_frame_arbiter_rr_arb2.sv | 21 ++
 rtl/tx_frame_arbiter.sv | 143 ++++++++++++++
 tb/tb_tx_frame_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs232_pkg.sv
// Shared definitions for the RS-232 frame transmit path: frame geometry and
// the arbiter state encoding.
package rs232_pkg;

  localparam int FRAME_BYTES    = 8;
  localparam int DEFAULT_DATA_W = FRAME_BYTES * 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    GAP   = 3'd4
  } arb_state_e;

endpackage

// File: rtl/tx_frame_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone requester always wins, a tie goes to the
// requester that did not own the previous frame.
module rr_arb2 (
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic grant,
  output logic grant_valid
);

  always_comb begin
    grant_valid = valid0 | valid1;
    grant       = 1'b0;
    if (valid0 && valid1) begin
      grant = ~last_grant;
    end else if (valid1) begin
      grant = 1'b1;
    end
  end

endmodule

// File: rtl/tx_frame_arbiter.sv
// Shares one 64-bit RS-232 frame transmitter between two block requesters:
// round-robin grant, start pulse, completion wait, idle gap and start timeout.
module tx_frame_arbiter
  import rs232_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int GAP_CYCLES = 32,
  parameter int START_TMO  = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  input  logic              tx_done,
  output logic              grant_id,
  output logic              busy,
  output logic              err_tmo,
  input  logic              err_clr
);

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam int TMO_W = $clog2(START_TMO + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(START_TMO - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(START_TMO);

  arb_state_e        state_q, state_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              grant_id_q, grant_id_d;
  logic              last_grant_q, last_grant_d;
  logic              seen_busy_q, seen_busy_d;
  logic              err_tmo_q, err_tmo_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [TMO_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              err_set;
  logic              arb_grant;
  logic              arb_valid;

  rr_arb2 u_rr_arb2 (
    .valid0      (req0_valid),
    .valid1      (req1_valid),
    .last_grant  (last_grant_q),
    .grant       (arb_grant),
    .grant_valid (arb_valid)
  );

  always_comb begin
    state_d      = state_q;
    tx_data_d    = tx_data_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    seen_busy_d  = seen_busy_q;
    gap_cnt_d    = gap_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    err_set      = 1'b0;

    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          tx_data_d    = arb_grant ? req1_data : req0_data;
          grant_id_d   = arb_grant;
          last_grant_d = arb_grant;
          state_d      = LOAD;
        end
      end
      LOAD: state_d = START;
      START: begin
        wait_cnt_d  = '0;
        seen_busy_d = 1'b0;
        state_d     = WAIT;
      end
      WAIT: begin
        seen_busy_d = seen_busy_q | tx_busy;
        if (wait_cnt_q != TMO_MAX) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
        // Completion wins over a coincident timeout threshold.
        if (tx_done) begin
          gap_cnt_d = '0;
          state_d   = GAP;
        end else if (!seen_busy_q && (wait_cnt_q == TMO_LAST)) begin
          err_set   = 1'b1;
          gap_cnt_d = '0;
          state_d   = GAP;
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (err_set) begin
      err_tmo_d = 1'b1;
    end else if (err_clr) begin
      err_tmo_d = 1'b0;
    end else begin
      err_tmo_d = err_tmo_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      tx_data_q    <= '0;
      grant_id_q   <= 1'b0;
      last_grant_q <= 1'b1;
      seen_busy_q  <= 1'b0;
      err_tmo_q    <= 1'b0;
      gap_cnt_q    <= '0;
      wait_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      tx_data_q    <= tx_data_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      seen_busy_q  <= seen_busy_d;
      err_tmo_q    <= err_tmo_d;
      gap_cnt_q    <= gap_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  assign req0_ready = (state_q == LOAD) && !grant_id_q;
  assign req1_ready = (state_q == LOAD) &&  grant_id_q;
  assign tx_start   = (state_q == START);
  assign busy       = (state_q != IDLE);
  assign tx_data    = tx_data_q;
  assign grant_id   = grant_id_q;
  assign err_tmo    = err_tmo_q;

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Bench for tx_frame_arbiter: scenario tasks checked against a frame-level
// model of the round-robin rule and the frame timing arithmetic.
module tb_tx_frame_arbiter;

  localparam int DW  = 64;
  localparam int GAP = 5;
  localparam int TMO = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req1_valid, req0_ready, req1_ready;
  logic [DW-1:0] req0_data, req1_data, tx_data;
  logic          tx_start, tx_busy, tx_done, grant_id, busy, err_tmo, err_clr;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit m_last;

  tx_frame_arbiter #(.DATA_W(DW), .GAP_CYCLES(GAP), .START_TMO(TMO)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy), .tx_done(tx_done),
    .grant_id(grant_id), .busy(busy), .err_tmo(err_tmo), .err_clr(err_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit exp_winner(bit v0, bit v1);
    if (v0 && !v1) return 1'b0;
    if (v1 && !v0) return 1'b1;
    return !m_last;
  endfunction

  function automatic logic [DW-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output logic r0, output logic r1, output bit ok);
    ok = 0; r0 = 0; r1 = 0;
    for (int i = 0; i < 100; i++) begin
      if (req0_ready || req1_ready) begin
        r0 = req0_ready; r1 = req1_ready; ok = 1;
        return;
      end
      tick();
    end
  endtask

  task automatic wait_idle(output int c, output bit ok);
    ok = 0; c = 0;
    for (int i = 0; i < 200; i++) begin
      if (!busy) begin
        c = cyc; ok = 1;
        return;
      end
      tick();
    end
  endtask

  // Transmitter model: called in the tx_start cycle, pulses tx_done `delay` cycles later.
  task automatic transmit(input int delay, input bit use_busy, output int done_cyc);
    tx_busy = use_busy;
    repeat (delay) tick();
    tx_done = 1'b1;
    done_cyc = cyc;
    tick();
    tx_done = 1'b0;
    tx_busy = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_last = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++;
    if ({req0_ready, req1_ready, tx_start, busy, err_tmo, grant_id} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {req0_ready, req1_ready, tx_start, busy, err_tmo, grant_id});
    end
    checks++;
    if (tx_data !== '0) begin
      errors++; $display("FAIL reset_tx_data: got %h expected 0", tx_data);
    end
    rst = 1'b0;
    m_last = 1'b1;
    tick();
    $display("reset: ctrl=%b tx_data=%h", {req0_ready, req1_ready, tx_start, busy}, tx_data);
  endtask

  task automatic test_single();
    logic [DW-1:0] d;
    int dc, c;
    bit ok;
    d = 64'h0123_4567_89AB_CDEF;
    req0_data = d; req0_valid = 1'b1;
    tick();
    checks++;
    if ({req0_ready, req1_ready, tx_start} !== 3'b100) begin
      errors++; $display("FAIL single_ready: got %b expected 100", {req0_ready, req1_ready, tx_start});
    end
    req0_valid = 1'b0;
    tick();
    checks++;
    if (tx_start !== 1'b1 || grant_id !== 1'b0) begin
      errors++; $display("FAIL single_start: got start=%b gid=%b expected 1 0", tx_start, grant_id);
    end
    checks++;
    if (tx_data !== d) begin
      errors++; $display("FAIL single_data: got %h expected %h", tx_data, d);
    end
    m_last = 1'b0;
    transmit(100, 1'b1, dc);
    wait_idle(c, ok);
    checks++;
    if (!ok || (c - dc) != GAP + 1) begin
      errors++; $display("FAIL single_gap: got %0d expected %0d (ok=%0d)", c - dc, GAP + 1, ok);
    end
    $display("single: tx_data=%h done->idle=%0d", tx_data, c - dc);
  endtask

  // Random valid patterns (lone or tied) checked against the round-robin rule.
  task automatic test_arbitration(input int frames, input bit force_tie, input string tag);
    logic r0, r1;
    logic [DW-1:0] exp_d;
    bit ok, v0, v1, w;
    int dc, c;
    for (int f = 0; f < frames; f++) begin
      if (force_tie) begin
        v0 = 1; v1 = 1;
      end else begin
        case ($urandom_range(2, 0))
          0: begin v0 = 1; v1 = 0; end
          1: begin v0 = 0; v1 = 1; end
          default: begin v0 = 1; v1 = 1; end
        endcase
      end
      req0_data = rnd64(); req1_data = rnd64();
      req0_valid = v0; req1_valid = v1;
      w = exp_winner(v0, v1);
      exp_d = w ? req1_data : req0_data;
      wait_ready(r0, r1, ok);
      checks++;
      if (!ok || {r0, r1} !== (w ? 2'b01 : 2'b10)) begin
        errors++; $display("FAIL %s_ready[%0d]: got %b expected %b", tag, f, {r0, r1}, w ? 2'b01 : 2'b10);
        req0_valid = 0; req1_valid = 0;
        return;
      end
      req0_valid = 0; req1_valid = 0;
      tick();
      checks++;
      if (tx_start !== 1'b1 || grant_id !== w || tx_data !== exp_d) begin
        errors++;
        $display("FAIL %s_frame[%0d]: got start=%b gid=%b data=%h expected 1 %b %h",
                 tag, f, tx_start, grant_id, tx_data, w, exp_d);
      end
      m_last = w;
      transmit($urandom_range(30, 3), 1'b1, dc);
      wait_idle(c, ok);
      checks++;
      if (!ok) begin
        errors++; $display("FAIL %s_idle[%0d]: got busy=%b expected 0", tag, f, busy);
      end
      $display("%s[%0d]: v=%b%b grant=%0d data=%h", tag, f, v0, v1, grant_id, tx_data);
    end
  endtask

  task automatic test_back_to_back();
    logic r0, r1;
    logic [DW-1:0] exp_d;
    bit ok;
    int dc, prev_done, c;
    prev_done = 0;
    req1_data = rnd64(); req1_valid = 1'b1;
    for (int f = 0; f < 3; f++) begin
      wait_ready(r0, r1, ok);
      checks++;
      if (!ok || {r0, r1} !== 2'b01) begin
        errors++; $display("FAIL b2b_ready[%0d]: got %b expected 01", f, {r0, r1});
        req1_valid = 0;
        return;
      end
      exp_d = req1_data;
      req1_data = rnd64();
      if (f == 2) req1_valid = 1'b0;
      tick();
      checks++;
      if (tx_start !== 1'b1 || tx_data !== exp_d) begin
        errors++; $display("FAIL b2b_start[%0d]: got start=%b data=%h expected 1 %h", f, tx_start, tx_data, exp_d);
      end
      if (f > 0) begin
        checks++;
        if (cyc - prev_done != GAP + 3) begin
          errors++; $display("FAIL b2b_spacing[%0d]: got %0d expected %0d", f, cyc - prev_done, GAP + 3);
        end
      end
      m_last = 1'b1;
      transmit($urandom_range(12, 2), 1'b1, prev_done);
      $display("b2b[%0d]: data=%h done_cyc=%0d", f, exp_d, prev_done);
    end
    wait_idle(c, ok);
  endtask

  // Issue one lone request and return in its tx_start cycle.
  task automatic launch(input bit which, output int s, output bit ok);
    logic r0, r1;
    if (which) begin req1_data = rnd64(); req1_valid = 1; end
    else begin req0_data = rnd64(); req0_valid = 1; end
    wait_ready(r0, r1, ok);
    req0_valid = 0; req1_valid = 0;
    tick();
    ok = ok && (tx_start === 1'b1);
    s = cyc;
    m_last = which;
  endtask

  task automatic test_timeout();
    int s, c;
    bit ok;
    tx_busy = 1'b0;
    launch(1'b0, s, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL tmo_launch: got no start expected start"); return; end
    repeat (TMO) tick();
    checks++;
    if (err_tmo !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL tmo_early: got err=%b busy=%b expected 0 1", err_tmo, busy);
    end
    tick();
    checks++;
    if (err_tmo !== 1'b1) begin
      errors++; $display("FAIL tmo_set: got %b expected 1 at start+%0d", err_tmo, TMO + 1);
    end
    wait_idle(c, ok);
    checks++;
    if (!ok || c != s + TMO + GAP + 1 || err_tmo !== 1'b1) begin
      errors++; $display("FAIL tmo_gap: got idle at %0d err=%b expected %0d 1", c - s, err_tmo, TMO + GAP + 1);
    end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    checks++;
    if (err_tmo !== 1'b0) begin
      errors++; $display("FAIL tmo_clr: got %b expected 0", err_tmo);
    end
    $display("timeout: set and cleared, idle after %0d cycles", c - s);

    launch(1'b1, s, ok);
    repeat (TMO) tick();
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    checks++;
    if (err_tmo !== 1'b1) begin
      errors++; $display("FAIL tmo_set_over_clr: got %b expected 1", err_tmo);
    end
    wait_idle(c, ok);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    $display("timeout: set beats clear, err=%b", err_tmo);

    launch(1'b0, s, ok);
    repeat (TMO) tick();
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    checks++;
    if (err_tmo !== 1'b0) begin
      errors++; $display("FAIL tmo_done_at_threshold: got %b expected 0", err_tmo);
    end
    wait_idle(c, ok);
    checks++;
    if (!ok || c != s + TMO + GAP + 1) begin
      errors++; $display("FAIL tmo_done_gap: got %0d expected %0d", c - s, TMO + GAP + 1);
    end
    $display("timeout: done at threshold, err=%b", err_tmo);
  endtask

  task automatic test_reset_wait();
    logic r0, r1;
    logic [DW-1:0] d0, d1;
    int s, dc, c;
    bit ok;
    launch(1'b1, s, ok);
    tx_busy = 1'b1;
    repeat (3) tick();
    d0 = rnd64(); d1 = rnd64();
    req0_data = d0; req1_data = d1; req0_valid = 1; req1_valid = 1;
    rst = 1'b1;
    #1;
    checks++;
    if ({req0_ready, req1_ready, tx_start, busy, err_tmo, grant_id} !== 6'b0 || tx_data !== '0) begin
      errors++;
      $display("FAIL rst_wait_outputs: got %b data=%h expected 000000 0",
               {req0_ready, req1_ready, tx_start, busy, err_tmo, grant_id}, tx_data);
    end
    tx_busy = 1'b0;
    tick();
    rst = 1'b0;
    m_last = 1'b1;
    for (int f = 0; f < 2; f++) begin
      bit w;
      w = exp_winner(req0_valid, req1_valid);
      wait_ready(r0, r1, ok);
      if (w) req1_valid = 0; else req0_valid = 0;
      tick();
      checks++;
      if (!ok || {r0, r1} !== (w ? 2'b01 : 2'b10) || tx_data !== (w ? d1 : d0) || grant_id !== w) begin
        errors++;
        $display("FAIL rst_wait_grant[%0d]: got rdy=%b data=%h gid=%b expected %b %h %b",
                 f, {r0, r1}, tx_data, grant_id, w ? 2'b01 : 2'b10, w ? d1 : d0, w);
      end
      m_last = w;
      transmit(4, 1'b1, dc);
      wait_idle(c, ok);
      $display("rst_wait[%0d]: grant=%0d data=%h", f, grant_id, tx_data);
    end
  endtask

  task automatic test_spurious();
    int s, dc, c;
    bit ok;
    for (int i = 0; i < 4; i++) begin
      tx_done = 1'b1; tx_busy = 1'b1;
      tick();
      checks++;
      if ({tx_start, busy, req0_ready, req1_ready} !== 4'b0) begin
        errors++; $display("FAIL spur_idle[%0d]: got %b expected 0000", i, {tx_start, busy, req0_ready, req1_ready});
      end
    end
    tx_done = 1'b0; tx_busy = 1'b0;
    launch(1'b0, s, ok);
    transmit(6, 1'b1, dc);
    tx_done = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (tx_start !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL spur_gap[%0d]: got start=%b busy=%b expected 0 1", i, tx_start, busy);
      end
    end
    tx_done = 1'b0;
    wait_idle(c, ok);
    checks++;
    if (!ok || c - dc != GAP + 1) begin
      errors++; $display("FAIL spur_gap_len: got %0d expected %0d", c - dc, GAP + 1);
    end
    $display("spurious: gap length %0d", c - dc);
  endtask

  initial begin
    rst = 1'b1; req0_valid = 0; req1_valid = 0; req0_data = '0; req1_data = '0;
    tx_busy = 0; tx_done = 0; err_clr = 0; m_last = 1'b1;
    test_reset();
    test_single();
    do_reset();
    test_arbitration(4, 1'b1, "tie");
    test_back_to_back();
    test_arbitration(8, 1'b0, "random");
    test_timeout();
    test_reset_wait();
    test_spurious();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
